mem_stage_data_memory: RTL and testbench



---
 rtl/mem_stage_data_memory_pkg.sv | 39 +++
 rtl/mem_load_extend.sv | 35 +++
 rtl/mem_stage_data_memory.sv | 82 ++++++++
 tb/tb_mem_stage_data_memory.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/mem_stage_data_memory_pkg.sv
// Shared constants for the MEM-stage data memory: access sizes and byte-lane masks.
// Byte-enable helper used by the store path.
package mem_stage_data_memory_pkg;

  localparam logic [1:0] DT_WORD = 2'b00;
  localparam logic [1:0] DT_HALF = 2'b01;
  localparam logic [1:0] DT_BYTE = 2'b10;

  localparam logic [3:0] MASK_B0 = 4'b0001;
  localparam logic [3:0] MASK_B1 = 4'b0010;
  localparam logic [3:0] MASK_B2 = 4'b0100;
  localparam logic [3:0] MASK_B3 = 4'b1000;
  localparam logic [3:0] MASK_H0 = 4'b0011;
  localparam logic [3:0] MASK_H1 = 4'b1100;
  localparam logic [3:0] MASK_W  = 4'b1111;

  // Reserved size 2'b11 falls through to a full word.
  function automatic logic [3:0] byte_en(
    input logic [1:0] dt,
    input logic [1:0] off
  );
    logic [3:0] m;
    m = MASK_W;
    unique case (1'b1)
      (dt == DT_HALF): m = off[1] ? MASK_H1 : MASK_H0;
      (dt == DT_BYTE): begin
        unique case (off)
          2'd0: m = MASK_B0;
          2'd1: m = MASK_B1;
          2'd2: m = MASK_B2;
          default: m = MASK_B3;
        endcase
      end
      default: m = MASK_W;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_load_extend.sv
// Load lane select and sign extension; combinational.
// Shared with the MEM/WB forwarding path.
module mem_load_extend
  import mem_stage_data_memory_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  dt_i,
  output logic [31:0] data_o
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = word_i[7:0];
    unique case (off_i)
      2'd0: b = word_i[7:0];
      2'd1: b = word_i[15:8];
      2'd2: b = word_i[23:16];
      default: b = word_i[31:24];
    endcase
    h = off_i[1] ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    data_o = word_i;
    unique case (1'b1)
      (dt_i == DT_HALF): data_o = {{16{h[15]}}, h};
      (dt_i == DT_BYTE): data_o = {{24{b[7]}}, b};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_stage_data_memory.sv
// MEM-stage data memory: lane-merged stores, sign-extended combinational loads.
// Optional misalignment trap enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_stage_data_memory
  import mem_stage_data_memory_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [1:0]  Datatype,
  output logic [31:0] ReadData,
  output logic        Misaligned
);

  logic [31:0]       mem_q [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic [1:0]        off;
  logic [31:0]       rd_word;
  logic [31:0]       ld_data;
  logic [3:0]        be;
  logic [31:0]       wsrc;
  logic [31:0]       wdata_d;
  logic              we_d;
  logic              misal;
  logic              unused_addr;

  assign idx         = Address[ADDR_W+1:2];
  assign off         = Address[1:0];
  assign rd_word     = mem_q[idx];
  assign unused_addr = ^Address[31:ADDR_W+2];

`ifdef MEM_MISALIGN_TRAP_EN
  always_comb begin
    misal = 1'b0;
    unique case (1'b1)
      (Datatype == DT_HALF): misal = off[0];
      (Datatype == DT_BYTE): misal = 1'b0;
      default: misal = (off != 2'b00);
    endcase
  end
`else
  assign misal = 1'b0;
`endif

  mem_load_extend u_ext (
    .word_i (rd_word),
    .off_i  (off),
    .dt_i   (Datatype),
    .data_o (ld_data)
  );

  always_comb begin
    be   = byte_en(Datatype, off);
    wsrc = WriteData;
    unique case (1'b1)
      (Datatype == DT_HALF): wsrc = {2{WriteData[15:0]}};
      (Datatype == DT_BYTE): wsrc = {4{WriteData[7:0]}};
      default: wsrc = WriteData;
    endcase
    for (int i = 0; i < 4; i++) begin
      wdata_d[i*8 +: 8] = be[i] ? wsrc[i*8 +: 8] : rd_word[i*8 +: 8];
    end
    we_d = MemWrite & ~Rst & ~misal;
  end

  always_comb begin
    ReadData   = '0;
    Misaligned = misal & ~Rst;
    if (MemRead && !Rst && !misal) ReadData = ld_data;
  end

  // Contents survive reset; only the write is gated.
  always_ff @(posedge Clk) begin
    if (we_d) mem_q[idx] <= wdata_d;
  end

endmodule

// File: tb/tb_mem_stage_data_memory.sv
// Directed bench for mem_stage_data_memory.
// Misalignment expectations follow MEM_MISALIGN_TRAP_EN.
module tb_mem_stage_data_memory;

  localparam int DEPTH = 1024;

  logic        Clk;
  logic        Rst;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [1:0]  Datatype;
  logic [31:0] ReadData;
  logic        Misaligned;

  int checks = 0;
  int errors = 0;

  mem_stage_data_memory #(.DEPTH(DEPTH), .ADDR_W(10)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .Address    (Address),
    .WriteData  (WriteData),
    .MemWrite   (MemWrite),
    .MemRead    (MemRead),
    .Datatype   (Datatype),
    .ReadData   (ReadData),
    .Misaligned (Misaligned)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [1:0] dt);
    Address   = a;
    WriteData = d;
    Datatype  = dt;
    MemWrite  = 1'b1;
    MemRead   = 1'b0;
    @(posedge Clk);
    #1;
    MemWrite  = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a,
                    input logic [1:0] dt, input logic [31:0] exp);
    Address  = a;
    Datatype = dt;
    MemRead  = 1'b1;
    #1;
    chk(tag, ReadData, exp);
    MemRead  = 1'b0;
  endtask

  initial begin
    Rst = 1'b1; Address = 32'h0; WriteData = 32'h0;
    MemWrite = 1'b0; MemRead = 1'b1; Datatype = 2'b00;
    repeat (2) @(negedge Clk);
    chk("reset_rdata", ReadData, 32'h0);
    chk("reset_misal", {31'h0, Misaligned}, 32'h0);
    Rst = 1'b0; MemRead = 1'b0;
    @(negedge Clk);

    wr(32'h10, 32'hDEADBEEF, 2'b00);
    rd("word_load", 32'h10, 2'b00, 32'hDEADBEEF);
    #1;
    chk("noread_zero", ReadData, 32'h0);

    wr(32'h10, 32'h0, 2'b00);
    wr(32'h13, 32'h80, 2'b10);
    rd("byte_merge_word", 32'h10, 2'b00, 32'h80000000);
    rd("byte_load_sext", 32'h13, 2'b10, 32'hFFFFFF80);
    rd("byte_load_zero", 32'h12, 2'b10, 32'h0);

    wr(32'h20, 32'h11112222, 2'b00);
    wr(32'h22, 32'h00007FFF, 2'b01);
    rd("half_merge_word", 32'h20, 2'b00, 32'h7FFF2222);
    rd("half_load_lo", 32'h20, 2'b01, 32'h00002222);
    rd("half_load_hi", 32'h22, 2'b01, 32'h00007FFF);

    wr(32'h24, 32'h0, 2'b00);
    wr(32'h24, 32'hFFFFFF11, 2'b10);
    wr(32'h25, 32'h000000AB, 2'b10);
    wr(32'h26, 32'h12348001, 2'b01);
    rd("b2b_merge_word", 32'h24, 2'b00, 32'h8001AB11);
    rd("b2b_half_sext", 32'h26, 2'b01, 32'hFFFF8001);
    rd("b2b_byte_sext", 32'h25, 2'b10, 32'hFFFFFFAB);
    rd("reserved_dt_word", 32'h24, 2'b11, 32'h8001AB11);

    wr(32'h30, 32'h1, 2'b00);
    Address = 32'h30; WriteData = 32'h2; Datatype = 2'b00;
    MemWrite = 1'b1; MemRead = 1'b1;
    #1;
    chk("rw_same_old", ReadData, 32'h1);
    @(posedge Clk);
    #1;
    MemWrite = 1'b0;
    #1;
    chk("rw_same_new", ReadData, 32'h2);
    MemRead = 1'b0;

    wr(32'h40, 32'h12345678, 2'b00);
    Rst = 1'b1; Address = 32'h40; WriteData = 32'hCAFEF00D;
    Datatype = 2'b00; MemWrite = 1'b1; MemRead = 1'b1;
    #1;
    chk("rst_rdata_zero", ReadData, 32'h0);
    @(posedge Clk);
    #1;
    Rst = 1'b0; MemWrite = 1'b0;
    #1;
    chk("rst_write_dropped", ReadData, 32'h12345678);
    MemRead = 1'b0;

    wr(32'h40 + DEPTH * 4, 32'hA5A5A5A5, 2'b00);
    rd("alias_low", 32'h40, 2'b00, 32'hA5A5A5A5);
    rd("alias_high", 32'h40 + DEPTH * 4, 2'b00, 32'hA5A5A5A5);

    Address = 32'h41; WriteData = 32'h55AA55AA; Datatype = 2'b00;
    MemWrite = 1'b1; MemRead = 1'b0;
    #1;
`ifdef MEM_MISALIGN_TRAP_EN
    chk("misal_word_flag", {31'h0, Misaligned}, 32'h1);
`else
    chk("misal_word_flag", {31'h0, Misaligned}, 32'h0);
`endif
    @(posedge Clk);
    #1;
    MemWrite = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    rd("misal_word_store", 32'h40, 2'b00, 32'hA5A5A5A5);
    rd("misal_half_load", 32'h21, 2'b01, 32'h0);
`else
    rd("misal_word_store", 32'h40, 2'b00, 32'h55AA55AA);
    rd("misal_half_load", 32'h21, 2'b01, 32'h00002222);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
